// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the pixel writer: FSM state encoding, pixel record
// layout {x, y, color, last} (MSB to LSB) and address-width derivation.
package pixel_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2
  } wr_state_t;

  // ceil(log2(n)), never less than 1 so a field is always at least one bit wide
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_bits(input int w, input int h);
    return clog2_min1(w * h);
  endfunction

  function automatic int pixel_bits(input int x_bits, input int y_bits, input int color_bits);
    return x_bits + y_bits + color_bits + 1;
  endfunction

endpackage

// File: rtl/pixel_writer_fifo.sv
// Small synchronous FIFO buffering pixel records between renderer and write FSM.
// Push is ignored while full and pop while empty, so callers may request either freely.
module pixel_fifo
  import pixel_writer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_BITS = clog2_min1(DEPTH);
  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]  storage [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic do_push;
  logic do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = storage[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Buffers renderer pixels and writes them to a framebuffer at y*SCREEN_W + x.
// Optional PIXEL_CLIP_EN drops off-screen pixels and counts them in drop_count.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int  SCREEN_W   = 160,
  parameter int  SCREEN_H   = 120,
  parameter int  FIFO_DEPTH = 4,
  parameter int  COLOR_BITS = 3,
  localparam int X_BITS     = clog2_min1(SCREEN_W),
  localparam int Y_BITS     = clog2_min1(SCREEN_H),
  localparam int ADDR_BITS  = addr_bits(SCREEN_W, SCREEN_H)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [X_BITS-1:0]     in_x,
  input  logic [Y_BITS-1:0]     in_y,
  input  logic [COLOR_BITS-1:0] in_color,
  input  logic                  in_last,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [COLOR_BITS-1:0] mem_data,
  output logic                  mem_we,
  input  logic                  mem_busy,
  output logic                  shape_done,
  output logic [15:0]           drop_count
);

  localparam int PIX_BITS = pixel_bits(X_BITS, Y_BITS, COLOR_BITS);

  typedef struct packed {
    logic [X_BITS-1:0]     x;
    logic [Y_BITS-1:0]     y;
    logic [COLOR_BITS-1:0] color;
    logic                  last;
  } pixel_t;

  wr_state_t state;
  pixel_t    hold;
  pixel_t    fifo_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_pop;
  logic      clip_drop;
  logic      we_last;
  logic      drop_pulse;
  logic [PIX_BITS-1:0] fifo_rdata;

  assign in_ready  = !fifo_full;
  assign fifo_head = pixel_t'(fifo_rdata);

  pixel_fifo #(
    .WIDTH (PIX_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (in_valid && in_ready),
    .push_data ({in_x, in_y, in_color, in_last}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef PIXEL_CLIP_EN
  assign clip_drop = (state == ST_CALC) &&
                     ((32'(hold.x) >= SCREEN_W) || (32'(hold.y) >= SCREEN_H));
`else
  assign clip_drop = 1'b0;
  assign drop_count = 16'd0;
`endif

  // The head is popped whenever the FSM moves a new pixel into the holding register
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || clip_drop ||
                     ((state == ST_WRITE) && !mem_busy));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      hold       <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      we_last    <= 1'b0;
      drop_pulse <= 1'b0;
      shape_done <= 1'b0;
`ifdef PIXEL_CLIP_EN
      drop_count <= 16'd0;
`endif
    end else begin
      mem_we     <= 1'b0;
      drop_pulse <= 1'b0;
      shape_done <= (mem_we && we_last) || drop_pulse;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            hold  <= fifo_head;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (clip_drop) begin
`ifdef PIXEL_CLIP_EN
            if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
`endif
            drop_pulse <= hold.last;
            if (!fifo_empty) begin
              hold  <= fifo_head;
              state <= ST_CALC;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            mem_addr <= ADDR_BITS'(hold.y) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(hold.x);
            mem_data <= hold.color;
            we_last  <= hold.last;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Address and data stay registered while the framebuffer stalls
          if (!mem_busy) begin
            mem_we <= 1'b1;
            if (!fifo_empty) begin
              hold  <= fifo_head;
              state <= ST_CALC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed self-checking bench for pixel_writer (default parameters);
// clip-specific expectations follow PIXEL_CLIP_EN.
module tb_pixel_writer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_color;
  logic        in_last;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        mem_busy;
  logic        shape_done;
  logic [15:0] drop_count;

  int checks = 0;
  int fails  = 0;
  int wr_addr[$];
  int wr_data[$];
  int done_count = 0;
  bit saw_full = 1'b0;

  always #5 clock = ~clock;

  pixel_writer dut (
    .clock      (clock),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_color   (in_color),
    .in_last    (in_last),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_busy   (mem_busy),
    .shape_done (shape_done),
    .drop_count (drop_count)
  );

  always @(negedge clock) begin
    if (mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_data));
    end
    if (shape_done) done_count++;
    if (!in_ready) saw_full = 1'b1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input int color, input bit last);
    int budget = 0;
    in_x     = 8'(x);
    in_y     = 7'(y);
    in_color = 3'(color);
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && budget < 200) begin
      @(posedge clock); #1;
      budget++;
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitWrites(input int target);
    int budget = 0;
    while (wr_addr.size() < target && budget < 300) begin
      @(negedge clock);
      budget++;
    end
    if (wr_addr.size() < target) checkOutput("write_timeout", wr_addr.size(), target);
  endtask

  initial begin
    int base;
    int done0;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_color = '0;
    in_last  = 1'b0;
    mem_busy = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_we", int'(mem_we), 0);
    checkOutput("rst_done", int'(shape_done), 0);
    checkOutput("rst_addr", int'(mem_addr), 0);
    checkOutput("rst_data", int'(mem_data), 0);
    checkOutput("rst_drop", int'(drop_count), 0);
    resetn = 1'b1;
    @(negedge clock);
    checkOutput("rst_ready", int'(in_ready), 1);

    // Single pixel, minimum latency and shape_done timing
    base = wr_addr.size();
    applyStimulus(3, 2, 5, 1);
    @(negedge clock); checkOutput("lat_we_n0", int'(mem_we), 0);
    @(negedge clock); checkOutput("lat_we_n1", int'(mem_we), 0);
    @(negedge clock); checkOutput("lat_we_n2", int'(mem_we), 0);
    @(negedge clock);
    checkOutput("single_we", int'(mem_we), 1);
    checkOutput("single_addr", int'(mem_addr), 323);
    checkOutput("single_data", int'(mem_data), 5);
    checkOutput("single_done_early", int'(shape_done), 0);
    @(negedge clock);
    checkOutput("single_we_off", int'(mem_we), 0);
    checkOutput("single_done", int'(shape_done), 1);
    @(negedge clock);
    checkOutput("single_done_off", int'(shape_done), 0);
    checkOutput("single_count", wr_addr.size() - base, 1);

    // Eight back-to-back pixels fill the FIFO and retire in order
    saw_full = 1'b0;
    base  = wr_addr.size();
    done0 = done_count;
    for (int i = 0; i < 8; i++) applyStimulus(i, 1, (i + 1) % 8, i == 7);
    waitWrites(base + 8);
    repeat (3) @(negedge clock);
    checkOutput("burst_full_seen", int'(saw_full), 1);
    checkOutput("burst_count", wr_addr.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < wr_addr.size()) begin
        checkOutput($sformatf("burst_addr%0d", i), wr_addr[base + i], 160 + i);
        checkOutput($sformatf("burst_data%0d", i), wr_data[base + i], (i + 1) % 8);
      end
    end
    checkOutput("burst_done", done_count - done0, 1);

    // Stalled framebuffer holds the write
    mem_busy = 1'b1;
    base = wr_addr.size();
    applyStimulus(10, 4, 2, 0);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput($sformatf("busy_we%0d", i), int'(mem_we), 0);
      checkOutput($sformatf("busy_addr%0d", i), int'(mem_addr), 650);
      checkOutput($sformatf("busy_data%0d", i), int'(mem_data), 2);
    end
    mem_busy = 1'b0;
    @(negedge clock);
    checkOutput("busy_release_we", int'(mem_we), 1);
    checkOutput("busy_release_addr", int'(mem_addr), 650);
    repeat (3) @(negedge clock);
    checkOutput("busy_count", wr_addr.size() - base, 1);

    base  = wr_addr.size();
    done0 = done_count;
`ifdef PIXEL_CLIP_EN
    applyStimulus(160, 0, 1, 1);
    applyStimulus(159, 119, 6, 0);
    waitWrites(base + 1);
    repeat (3) @(negedge clock);
    checkOutput("clip_drop_count", int'(drop_count), 1);
    checkOutput("clip_count", wr_addr.size() - base, 1);
    if (wr_addr.size() > base) begin
      checkOutput("clip_addr", wr_addr[base], 19199);
      checkOutput("clip_data", wr_data[base], 6);
    end
    checkOutput("clip_done", done_count - done0, 1);
`else
    applyStimulus(160, 0, 1, 1);
    waitWrites(base + 1);
    repeat (3) @(negedge clock);
    checkOutput("noclip_drop_count", int'(drop_count), 0);
    checkOutput("noclip_count", wr_addr.size() - base, 1);
    if (wr_addr.size() > base) checkOutput("noclip_addr", wr_addr[base], 160);
    checkOutput("noclip_done", done_count - done0, 1);
`endif

    // Reset while a write is stalled with three pixels queued
    mem_busy = 1'b1;
    base = wr_addr.size();
    for (int i = 0; i < 4; i++) applyStimulus(20 + i, 3, 4, 0);
    repeat (5) @(negedge clock);
    checkOutput("rstw_no_write_yet", wr_addr.size() - base, 0);
    resetn = 1'b0;
    @(negedge clock);
    mem_busy = 1'b0;
    @(negedge clock);
    checkOutput("rstw_we", int'(mem_we), 0);
    checkOutput("rstw_addr", int'(mem_addr), 0);
    resetn = 1'b1;
    @(negedge clock);
    checkOutput("rstw_ready", int'(in_ready), 1);
    repeat (10) @(negedge clock);
    checkOutput("rstw_aborted", wr_addr.size() - base, 0);
    checkOutput("rstw_fifo_empty", int'(dut.fifo_empty), 1);

    base = wr_addr.size();
    applyStimulus(1, 0, 7, 1);
    waitWrites(base + 1);
    if (wr_addr.size() > base) begin
      checkOutput("post_rst_addr", wr_addr[base], 1);
      checkOutput("post_rst_data", wr_data[base], 7);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
